ext_int_ctrl: RTL
=================

# ext_int_ctrl

External interrupt controller for the pipelined MIPS core. It collects up to NUM_SRC asynchronous peripheral interrupt lines, synchronizes and latches them, applies a software mask, and drives the single external interrupt request consumed by the core's datapath. It holds a request/acknowledge/end-of-interrupt handshake with the core and reports the serviced source ID. It sits directly upstream of the core's external interrupt input.

## Interface
- NUM_SRC, 8: number of interrupt sources, 1..32.
- EDGE_MASK, 32'h0000_00FF: bit i = 1 makes source i edge-triggered (rising); 0 makes it level-triggered (active-high).
- MASK_RST, 32'h0: reset value of the MASK register (1 = enabled).
- ID_W, 5: width of o_cause_id; must satisfy 2^ID_W >= NUM_SRC.

- i_clk  in  1  clock; all state on rising edge.
- i_a_rst  in  1  asynchronous, active-high reset.
- i_irq  in  NUM_SRC  raw interrupt lines, asynchronous to i_clk.
- i_ack  in  1  core takes the interrupt (single-cycle pulse).
- i_eoi  in  1  core finished the handler, i.e. eret retired (single-cycle pulse).
- i_we  in  1  register write strobe.
- i_addr  in  2  register select.
- i_wdata  in  32  write data.
- o_rdata  out  32  registered read data.
- o_ext_int  out  1  interrupt request to the core; registered.
- o_cause_id  out  ID_W  index of the source being serviced.
- o_in_service  out  1  high while a handler is active.

## Operation
- Registers selected by i_addr:
  - 0 MASK: read/write, bits >= NUM_SRC read 0.
  - 1 PENDING: read; a write clears edge bits written with 1 (W1C). Writes have no effect on level bits.
  - 2 CAUSE: read {o_in_service, 26'b0, o_cause_id} zero-extended.
  - 3: reads 0; writes are ignored.
- Pending bits:
  - Edge source: set on a synchronized 0->1 transition. Cleared by W1C, or when the source is acknowledged.
  - Level source: the pending bit equals the synchronized level every cycle.
- Eligible sources are PENDING & MASK. The lowest index has the highest priority.
- FSM states:
  - IDLE: o_ext_int=0. Goes to REQ when any source is eligible.
  - REQ: o_ext_int=1.
    - On i_ack: latch the highest-priority eligible ID into o_cause_id, clear that bit if it is an edge bit, and go to SERVICE.
    - If the eligible set becomes empty without i_ack (masked or cleared): return to IDLE.
    - If there is no eligible source in the i_ack cycle: o_cause_id=0, stay in IDLE, o_in_service stays 0.
  - SERVICE: o_ext_int=0, o_in_service=1. On i_eoi go to IDLE; o_cause_id holds its value.
- No nesting: new pending sources wait in PENDING during SERVICE.
- Ignored pulses: i_ack outside REQ and i_eoi outside SERVICE.
- Same-cycle conflicts:
  - A set event and a W1C on the same edge bit: set wins.
  - A set event and the ack-clear on the same bit: set wins, so the bit re-pends.
- Reset (while i_a_rst is high, at any time including mid-handshake):
  - FSM goes to IDLE.
  - o_ext_int=0, o_in_service=0, o_cause_id=0, o_rdata=0.
  - PENDING=0, synchronizer flops=0, MASK=MASK_RST.

## Timing
- o_rdata is valid one cycle after i_addr is presented. Reads have no side effects.
- A MASK write takes effect for eligibility on the next cycle.
- Request latency, E0 = first rising edge sampling i_irq high:
  - With sync: PENDING is set at E3, o_ext_int rises at E4.
  - Without sync: PENDING is set at E1, o_ext_int rises at E2.
- o_ext_int falls on the edge after the i_ack cycle. o_cause_id and o_in_service are updated on that same edge.
- After i_eoi, o_ext_int can re-rise at the earliest on the second edge after the i_eoi cycle (one IDLE cycle).
- Input pulses on edge sources must be at least 2 i_clk periods wide to be guaranteed detected.

## Configuration
- INT_CTRL_SYNC_EN defined: each i_irq bit passes through a 2-flop synchronizer before edge and level detection.
- INT_CTRL_SYNC_EN undefined: i_irq is sampled directly. Use this only for sources already synchronous to i_clk. All latencies shrink by 2 cycles.

## Test plan
- Edge request: MASK=0x01, pulse i_irq[0] for 3 cycles.
  - Expect PENDING=0x01 and o_ext_int=1 at E4 (sync build).
  - Then i_ack: o_cause_id=0, o_in_service=1, PENDING=0x00.
  - Then i_eoi: o_in_service=0.
- Priority: MASK=0xFF, raise i_irq[5] and i_irq[2] together, then i_ack.
  - Expect o_cause_id=2 and PENDING=0x20.
  - After i_eoi, o_ext_int re-asserts and the next ack gives o_cause_id=5.
- Masking: MASK=0x00, pulse i_irq[3].
  - Expect PENDING=0x08 and o_ext_int stays 0.
  - Write MASK=0x08: o_ext_int rises.
  - Write PENDING=0x08 (W1C) while in REQ: o_ext_int falls and the FSM returns to IDLE.
- Level source: EDGE_MASK bit 7 = 0, hold i_irq[7] high, ack, then i_eoi with the line still high.
  - Expect a re-request (o_ext_int=1) two edges after i_eoi.
  - Drop i_irq[7]: PENDING[7]=0.
- Reset mid-SERVICE: assert i_a_rst asynchronously.
  - Expect o_in_service, o_ext_int, o_cause_id, PENDING all 0 immediately, and MASK=MASK_RST.
  - Stray i_eoi after reset is ignored.

Source files
------------

// File: rtl/ext_int_ctrl_if.sv
// ext_int_ctrl_if: register bus and core handshake between the MIPS core and ext_int_ctrl.
interface ext_int_ctrl_if #(
   parameter int ID_W = 5
);
   logic            i_ack;
   logic            i_eoi;
   logic            i_we;
   logic [1:0]      i_addr;
   logic [31:0]     i_wdata;
   logic [31:0]     o_rdata;
   logic            o_ext_int;
   logic [ID_W-1:0] o_cause_id;
   logic            o_in_service;
   modport master (
      output i_ack, i_eoi, i_we, i_addr, i_wdata,
      input  o_rdata, o_ext_int, o_cause_id, o_in_service
   );
   modport slave (
      input  i_ack, i_eoi, i_we, i_addr, i_wdata,
      output o_rdata, o_ext_int, o_cause_id, o_in_service
   );
endinterface

// File: rtl/ext_int_ctrl.sv
// ext_int_ctrl: external interrupt controller with mask, fixed priority and ack/eoi handshake.
// Define INT_CTRL_SYNC_EN to put a 2-flop synchronizer on every i_irq line.
module ext_int_ctrl #(
   parameter int          NUM_SRC   = 8,
   parameter logic [31:0] EDGE_MASK = 32'h0000_00FF,
   parameter logic [31:0] MASK_RST  = 32'h0,
   parameter int          ID_W      = 5
) (
   input logic               i_clk,
   input logic               i_a_rst,
   input logic [NUM_SRC-1:0] i_irq,
   ext_int_ctrl_if.slave     bus
);
   localparam logic [1:0]  S_IDLE = 2'd0;
   localparam logic [1:0]  S_REQ  = 2'd1;
   localparam logic [1:0]  S_SVC  = 2'd2;
   localparam logic [31:0] VALID  = NUM_SRC >= 32 ? 32'hFFFF_FFFF : (32'd1 << NUM_SRC) - 32'd1;
   localparam logic [31:0] EDGE   = EDGE_MASK & VALID;
   logic [NUM_SRC-1:0] irq_in;
   logic [31:0]        irq_q, irq_p_q;
   logic [31:0]        pend_q, pend_d, mask_q, mask_d, rdata_q, rdata_d;
   logic [31:0]        elig, rise, w1c, ack_clr;
   logic [1:0]         state_q, state_d;
   logic [ID_W-1:0]    cause_q, cause_d, prio_id;
   logic               ext_int_q, ext_int_d, in_svc_q, in_svc_d, any, take;
`ifdef INT_CTRL_SYNC_EN
   logic [NUM_SRC-1:0] sync1_q, sync2_q;
   always_ff @(posedge i_clk or posedge i_a_rst) begin
      if (i_a_rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= i_irq;
         sync2_q <= sync1_q;
      end
   end
   assign irq_in = sync2_q;
`else
   assign irq_in = i_irq;
`endif
   always_comb begin
      elig    = pend_q & mask_q;
      any     = |elig;
      prio_id = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (elig[i]) prio_id = ID_W'(i);
      rise    = irq_q & ~irq_p_q;
      w1c     = (bus.i_we && bus.i_addr == 2'd1) ? bus.i_wdata & VALID : 32'd0;
      take    = state_q == S_REQ && bus.i_ack && any;
      ack_clr = take ? 32'd1 << prio_id : 32'd0;
      // set events win over both W1C and the ack-clear
      pend_d  = (EDGE & ((pend_q & ~w1c & ~ack_clr) | rise)) | (~EDGE & VALID & irq_q);
      mask_d  = (bus.i_we && bus.i_addr == 2'd0) ? bus.i_wdata & VALID : mask_q;
      state_d = state_q == S_IDLE ? (any ? S_REQ : S_IDLE)
              : state_q == S_REQ  ? (take ? S_SVC : (any ? S_REQ : S_IDLE))
              : state_q == S_SVC  ? (bus.i_eoi ? S_IDLE : S_SVC)
              : S_IDLE;
      cause_d   = (state_q == S_REQ && bus.i_ack) ? (any ? prio_id : '0) : cause_q;
      ext_int_d = state_d == S_REQ;
      in_svc_d  = state_d == S_SVC;
      rdata_d   = bus.i_addr == 2'd0 ? mask_q
                : bus.i_addr == 2'd1 ? pend_q
                : bus.i_addr == 2'd2 ? {in_svc_q, 31'(cause_q)}
                : 32'd0;
   end
   always_ff @(posedge i_clk or posedge i_a_rst) begin
      if (i_a_rst) begin
         irq_q     <= '0;
         irq_p_q   <= '0;
         pend_q    <= '0;
         mask_q    <= MASK_RST & VALID;
         state_q   <= S_IDLE;
         cause_q   <= '0;
         ext_int_q <= 1'b0;
         in_svc_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         irq_q     <= 32'(irq_in);
         irq_p_q   <= irq_q;
         pend_q    <= pend_d;
         mask_q    <= mask_d;
         state_q   <= state_d;
         cause_q   <= cause_d;
         ext_int_q <= ext_int_d;
         in_svc_q  <= in_svc_d;
         rdata_q   <= rdata_d;
      end
   end
   assign bus.o_rdata      = rdata_q;
   assign bus.o_ext_int    = ext_int_q;
   assign bus.o_cause_id   = cause_q;
   assign bus.o_in_service = in_svc_q;
endmodule
